// File: rtl/lt24_irq_ctrl.sv
// lt24_irq_ctrl: memory-mapped interrupt controller for the LT24 frame engine.
// Holds the pattern and per-channel velocity registers, turns finish_flag into
// a level or rising-edge interrupt, and keeps a capture/event-count pair.
module lt24_irq_ctrl #(
    parameter int NUM_CH    = 2,
    parameter int DATA_W    = 32,
    parameter int PATTERN_W = 12,
    parameter int CNT_W     = 32
) (
    input  logic                     clock_clk,
    input  logic                     reset_reset_n,
    input  logic [7:0]               avs_s0_address,
    input  logic                     avs_s0_read,
    input  logic                     avs_s0_write,
    input  logic [DATA_W-1:0]        avs_s0_writedata,
    output logic [DATA_W-1:0]        avs_s0_readdata,
    output logic                     avs_s0_waitrequest,
    output logic                     ins_irq0_irq,
    input  logic                     finish_flag,
    input  logic [CNT_W-1:0]         counter,
    output logic [PATTERN_W-1:0]     pattern,
    output logic [NUM_CH*DATA_W-1:0] vx,
    output logic [NUM_CH*DATA_W-1:0] vy
);

    localparam logic [7:0] ADDR_STATUS   = 8'd0;
    localparam logic [7:0] ADDR_COUNTER  = 8'd1;
    localparam logic [7:0] ADDR_PATTERN  = 8'd2;
    localparam logic [7:0] ADDR_CTRL     = 8'd3;
    localparam logic [7:0] ADDR_IRQ_CLR  = 8'd4;
    localparam logic [7:0] ADDR_EVT_CNT  = 8'd5;
    localparam logic [7:0] ADDR_CAPTURE  = 8'd6;
    localparam logic [7:0] ADDR_VEC_BASE = 8'd8;
    localparam int         CH_IDX_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                    prev_r;
    logic                    pending_r;
    logic                    overflow_r;
    logic                    irq_r;
    logic [1:0]              ctrl_r;
    logic [PATTERN_W-1:0]    pattern_r;
    logic [DATA_W-1:0]       vx_r [NUM_CH];
    logic [DATA_W-1:0]       vy_r [NUM_CH];
    logic [CNT_W-1:0]        capture_r;
    logic [15:0]             evt_cnt_r;
    logic [DATA_W-1:0]       readdata_r;

    logic                    rise_s;
    logic                    event_s;
    logic                    clr_pend_s;
    logic                    clr_ovf_s;
    logic                    wr_evt_s;
    logic [7:0]              ch_off_s;
    logic                    ch_hit_s;
    logic [CH_IDX_W-1:0]     ch_idx_s;
    logic [DATA_W-1:0]       rd_mux_s;

    // Velocity window: even offsets are vx, odd offsets are vy, pairs per channel.
    assign ch_off_s   = avs_s0_address - ADDR_VEC_BASE;
    assign ch_hit_s   = (avs_s0_address >= ADDR_VEC_BASE) &&
                        ({1'b0, ch_off_s[7:1]} < 8'(NUM_CH));
    assign ch_idx_s   = ch_off_s[CH_IDX_W:1];

    assign rise_s     = finish_flag & ~prev_r;
    assign event_s    = ctrl_r[1] ? rise_s : finish_flag;
    assign clr_pend_s = avs_s0_write && (avs_s0_address == ADDR_IRQ_CLR) && avs_s0_writedata[0];
    assign clr_ovf_s  = avs_s0_write && (avs_s0_address == ADDR_IRQ_CLR) && avs_s0_writedata[2];
    assign wr_evt_s   = avs_s0_write && (avs_s0_address == ADDR_EVT_CNT);

    // Read multiplexer over the pre-edge register values, narrow fields zero-extended.
    always_comb begin
        rd_mux_s = {DATA_W{1'b0}};
        case (avs_s0_address)
            ADDR_STATUS:  rd_mux_s = DATA_W'({overflow_r, pending_r, finish_flag});
            ADDR_COUNTER: rd_mux_s = DATA_W'(counter);
            ADDR_PATTERN: rd_mux_s = DATA_W'(pattern_r);
            ADDR_CTRL:    rd_mux_s = DATA_W'(ctrl_r);
            ADDR_EVT_CNT: rd_mux_s = DATA_W'(evt_cnt_r);
            ADDR_CAPTURE: rd_mux_s = DATA_W'(capture_r);
            default: begin
                if (ch_hit_s) begin
                    if (ch_off_s[0]) begin
                        rd_mux_s = vy_r[ch_idx_s];
                    end else begin
                        rd_mux_s = vx_r[ch_idx_s];
                    end
                end else begin
                    rd_mux_s = {DATA_W{1'b0}};
                end
            end
        endcase
    end

    // Read data register: loaded only on a read strobe, held otherwise.
    always_ff @(posedge clock_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            readdata_r <= {DATA_W{1'b0}};
        end else if (avs_s0_read) begin
            readdata_r <= rd_mux_s;
        end
    end

    // Pattern and control registers.
    always_ff @(posedge clock_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            pattern_r <= {PATTERN_W{1'b0}};
            ctrl_r    <= 2'b00;
        end else begin
            if (avs_s0_write && (avs_s0_address == ADDR_PATTERN)) begin
                pattern_r <= avs_s0_writedata[PATTERN_W-1:0];
            end
            if (avs_s0_write && (avs_s0_address == ADDR_CTRL)) begin
                ctrl_r <= avs_s0_writedata[1:0];
            end
        end
    end

    // Per-channel velocity registers.
    always_ff @(posedge clock_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                vx_r[i] <= {DATA_W{1'b0}};
                vy_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (avs_s0_write && ch_hit_s && (ch_idx_s == CH_IDX_W'(i))) begin
                    if (ch_off_s[0]) begin
                        vy_r[i] <= avs_s0_writedata;
                    end else begin
                        vx_r[i] <= avs_s0_writedata;
                    end
                end
            end
        end
    end

    // Interrupt state: a new event beats a same-cycle clear; irq follows pending by one edge.
    always_ff @(posedge clock_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            prev_r     <= 1'b0;
            pending_r  <= 1'b0;
            overflow_r <= 1'b0;
            irq_r      <= 1'b0;
        end else begin
            prev_r <= finish_flag;
            irq_r  <= pending_r & ctrl_r[0];
            if (event_s) begin
                pending_r <= 1'b1;
            end else if (clr_pend_s) begin
                pending_r <= 1'b0;
            end
            if (event_s && pending_r && ctrl_r[1]) begin
                overflow_r <= 1'b1;
            end else if (clr_ovf_s) begin
                overflow_r <= 1'b0;
            end
        end
    end

    // Counter capture and saturating event count, both on rising finish_flag.
    always_ff @(posedge clock_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            capture_r <= {CNT_W{1'b0}};
            evt_cnt_r <= 16'd0;
        end else begin
            if (rise_s) begin
                capture_r <= counter;
            end
            if (wr_evt_s) begin
                evt_cnt_r <= rise_s ? 16'd1 : 16'd0;
            end else if (rise_s && (evt_cnt_r != 16'hFFFF)) begin
                evt_cnt_r <= evt_cnt_r + 16'd1;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_vec_out
        assign vx[g*DATA_W +: DATA_W] = vx_r[g];
        assign vy[g*DATA_W +: DATA_W] = vy_r[g];
    end

    assign pattern            = pattern_r;
    assign avs_s0_readdata    = readdata_r;
    assign ins_irq0_irq       = irq_r;
    assign avs_s0_waitrequest = 1'b0;

endmodule

// File: tb/tb_lt24_irq_ctrl.sv
// Self-checking bench for lt24_irq_ctrl: vector table, directed corner
// sequences and randomized traffic against a register-level reference model.
module tb_lt24_irq_ctrl;

    localparam int NUM_CH    = 2;
    localparam int DATA_W    = 32;
    localparam int PATTERN_W = 12;
    localparam int CNT_W     = 32;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [7:0]               addr;
    logic                     rd;
    logic                     wr;
    logic [DATA_W-1:0]        wdata;
    logic [DATA_W-1:0]        readdata;
    logic                     waitrequest;
    logic                     irq;
    logic                     finish_flag;
    logic [CNT_W-1:0]         counter;
    logic [PATTERN_W-1:0]     pattern;
    logic [NUM_CH*DATA_W-1:0] vx;
    logic [NUM_CH*DATA_W-1:0] vy;

    always #5 clk = ~clk;

    lt24_irq_ctrl #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .PATTERN_W(PATTERN_W), .CNT_W(CNT_W)
    ) dut (
        .clock_clk          (clk),
        .reset_reset_n      (rst_n),
        .avs_s0_address     (addr),
        .avs_s0_read        (rd),
        .avs_s0_write       (wr),
        .avs_s0_writedata   (wdata),
        .avs_s0_readdata    (readdata),
        .avs_s0_waitrequest (waitrequest),
        .ins_irq0_irq       (irq),
        .finish_flag        (finish_flag),
        .counter            (counter),
        .pattern            (pattern),
        .vx                 (vx),
        .vy                 (vy)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: architectural register contents
    logic [PATTERN_W-1:0] m_pattern;
    logic [1:0]           m_ctrl;
    logic [DATA_W-1:0]    m_vx [NUM_CH];
    logic [DATA_W-1:0]    m_vy [NUM_CH];
    bit                   m_pend, m_ovf, m_prev, m_irq;
    logic [CNT_W-1:0]     m_cap;
    int                   m_evt;
    logic [DATA_W-1:0]    m_rd;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pattern = '0; m_ctrl = 2'b00; m_pend = 0; m_ovf = 0; m_prev = 0; m_irq = 0;
        m_cap = '0; m_evt = 0; m_rd = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_vx[i] = '0;
            m_vy[i] = '0;
        end
    endtask

    function automatic logic [DATA_W-1:0] m_read(input int a);
        case (a)
            0: return DATA_W'({m_ovf, m_pend, finish_flag});
            1: return DATA_W'(counter);
            2: return DATA_W'(m_pattern);
            3: return DATA_W'(m_ctrl);
            5: return DATA_W'(m_evt);
            6: return DATA_W'(m_cap);
            default: begin
                if (a >= 8 && a < 8 + 2*NUM_CH)
                    return (a % 2 == 0) ? m_vx[(a-8)/2] : m_vy[(a-8)/2];
                return '0;
            end
        endcase
    endfunction

    // One clock: model applies the register-map rules, then outputs are compared.
    task automatic cycle();
        bit rise, evt, edge_mode;
        int a;
        @(posedge clk);
        a         = int'(addr);
        edge_mode = m_ctrl[1];
        rise      = finish_flag && !m_prev;
        evt       = edge_mode ? rise : finish_flag;
        m_irq     = m_pend && m_ctrl[0];
        if (rd) m_rd = m_read(a);
        if (evt && m_pend && edge_mode) m_ovf = 1;
        else if (wr && a == 4 && wdata[2]) m_ovf = 0;
        if (evt) m_pend = 1;
        else if (wr && a == 4 && wdata[0]) m_pend = 0;
        if (wr && a == 5) m_evt = rise ? 1 : 0;
        else if (rise && m_evt < 65535) m_evt++;
        if (rise) m_cap = counter;
        if (wr) begin
            if (a == 2) m_pattern = wdata[PATTERN_W-1:0];
            if (a == 3) m_ctrl = wdata[1:0];
            if (a >= 8 && a < 8 + 2*NUM_CH) begin
                if (a % 2 == 0) m_vx[(a-8)/2] = wdata;
                else            m_vy[(a-8)/2] = wdata;
            end
        end
        m_prev = finish_flag;
        #1;
        chk("m_readdata", readdata, m_rd);
        chk("m_irq", irq, m_irq);
        chk("m_pattern", pattern, m_pattern);
        chk("m_vx", vx, {m_vx[1], m_vx[0]});
        chk("m_vy", vy, {m_vy[1], m_vy[0]});
    endtask

    task automatic idle(input bit ff);
        rd = 0; wr = 0; finish_flag = ff;
        cycle();
    endtask

    task automatic wr_reg(input logic [7:0] a, input logic [31:0] d);
        rd = 0; wr = 1; addr = a; wdata = d;
        cycle();
        wr = 0;
    endtask

    task automatic rd_reg(input logic [7:0] a, input logic [31:0] exp, input string name);
        rd = 1; wr = 0; addr = a;
        cycle();
        rd = 0;
        chk(name, readdata, exp);
    endtask

    initial begin
        rst_n = 0; addr = 8'd0; rd = 0; wr = 0; wdata = '0; finish_flag = 0; counter = 32'h55;
        model_reset();
        #1;
        chk("rst_readdata", readdata, 0);
        chk("rst_irq", irq, 0);
        chk("rst_pattern", pattern, 0);
        chk("rst_vx", vx, 0);
        chk("rst_vy", vy, 0);
        chk("waitrequest", waitrequest, 0);
        repeat (3) @(negedge clk);
        rst_n = 1;

        // Vector table: register map, zero-extension, unmapped space, read-before-write
        tbl[0]  = '{0, 1, 8'd10,  32'hDEADBEEF, 32'h0};
        tbl[1]  = '{0, 1, 8'd9,   32'h00001234, 32'h0};
        tbl[2]  = '{1, 0, 8'd10,  32'h0,        32'hDEADBEEF};
        tbl[3]  = '{1, 0, 8'd9,   32'h0,        32'h00001234};
        tbl[4]  = '{0, 1, 8'd2,   32'hFFFFFABC, 32'h0};
        tbl[5]  = '{1, 0, 8'd2,   32'h0,        32'h00000ABC};
        tbl[6]  = '{1, 1, 8'd2,   32'h00000123, 32'h00000ABC};
        tbl[7]  = '{1, 0, 8'd2,   32'h0,        32'h00000123};
        tbl[8]  = '{0, 1, 8'd3,   32'hFFFFFFFF, 32'h0};
        tbl[9]  = '{1, 0, 8'd3,   32'h0,        32'h00000003};
        tbl[10] = '{0, 1, 8'd3,   32'h0,        32'h0};
        tbl[11] = '{0, 1, 8'h7F,  32'hFFFFFFFF, 32'h0};
        tbl[12] = '{1, 0, 8'h7F,  32'h0,        32'h0};
        tbl[13] = '{0, 1, 8'd16,  32'h00000001, 32'h0};
        tbl[14] = '{1, 0, 8'd16,  32'h0,        32'h0};
        tbl[15] = '{1, 0, 8'd1,   32'h0,        32'h00000055};
        tbl[16] = '{1, 0, 8'd0,   32'h0,        32'h0};
        tbl[17] = '{1, 0, 8'd3,   32'h0,        32'h0};
        for (int i = 0; i < 18; i++) begin
            rd = tbl[i].rd; wr = tbl[i].wr; addr = tbl[i].addr; wdata = tbl[i].wdata;
            cycle();
            if (tbl[i].rd) chk($sformatf("tbl_%0d", i), readdata, tbl[i].exp);
        end
        rd = 0; wr = 0;
        chk("vx_pack", vx, 64'hDEADBEEF_00000000);
        chk("vy_pack", vy, 64'h00000000_00001234);

        // Edge mode with irq enabled: capture, count, status, irq latency
        wr_reg(8'd3, 32'h3);
        finish_flag = 1;
        cycle();
        chk("irq_not_yet", irq, 0);
        rd_reg(8'd0, 32'h3, "status_pend");
        chk("irq_asserted", irq, 1);
        finish_flag = 0;
        counter = 32'h77;
        rd_reg(8'd6, 32'h55, "capture");
        rd_reg(8'd5, 32'h1, "evt_cnt_one");

        // Two rising edges without a clear raise overflow; clearing both bits
        wr_reg(8'd4, 32'h5);
        idle(1); idle(0); idle(1); idle(0);
        rd_reg(8'd0, 32'h6, "status_ovf");
        wr_reg(8'd4, 32'h5);
        rd_reg(8'd0, 32'h0, "status_cleared");
        chk("irq_cleared", irq, 0);

        // Level mode: held event wins over a simultaneous clear
        wr_reg(8'd3, 32'h1);
        idle(1);
        wr_reg(8'd4, 32'h1);
        rd_reg(8'd0, 32'h3, "set_wins");
        idle(0);
        wr_reg(8'd4, 32'h1);
        rd_reg(8'd0, 32'h0, "level_cleared");

        // Event counter: counting, clear+increment, saturation
        wr_reg(8'd3, 32'h2);
        wr_reg(8'd5, 32'h0);
        for (int i = 0; i < 20; i++) begin
            idle(1);
            idle(0);
        end
        rd_reg(8'd5, 32'd20, "evt_cnt_20");
        finish_flag = 1;
        wr_reg(8'd5, 32'h0);
        idle(0);
        rd_reg(8'd5, 32'd1, "evt_clr_inc");
        @(negedge clk);
        force dut.evt_cnt_r = 16'hFFFD;
        #1;
        release dut.evt_cnt_r;
        m_evt = 32'hFFFD;
        for (int i = 0; i < 3; i++) begin
            idle(1);
            idle(0);
        end
        rd_reg(8'd5, 32'h0000FFFF, "evt_saturate");
        wr_reg(8'd5, 32'h1234);
        rd_reg(8'd5, 32'h0, "evt_write_clear");

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 15);
            addr = (r < 13) ? 8'(r) : ((r == 13) ? 8'h7F : 8'h10);
            rd = 1'($urandom_range(0, 1));
            wr = ($urandom_range(0, 3) == 0);
            wdata = $urandom;
            finish_flag = 1'($urandom_range(0, 1));
            counter = $urandom;
            cycle();
        end

        // Asynchronous reset mid-cycle with everything non-zero
        rd = 0; wr = 0;
        wr_reg(8'd2, 32'hFFF);
        wr_reg(8'd3, 32'h1);
        wr_reg(8'd8, 32'h11111111);
        wr_reg(8'd9, 32'h22222222);
        wr_reg(8'd10, 32'h33333333);
        wr_reg(8'd11, 32'h44444444);
        idle(1);
        idle(1);
        rd_reg(8'd8, 32'h11111111, "pre_reset_rd");
        chk("pre_reset_irq", irq, 1);
        @(posedge clk);
        #2;
        rst_n = 0;
        #1;
        chk("async_rst_readdata", readdata, 0);
        chk("async_rst_irq", irq, 0);
        chk("async_rst_pattern", pattern, 0);
        chk("async_rst_vx", vx, 0);
        chk("async_rst_vy", vy, 0);
        model_reset();
        @(negedge clk);
        finish_flag = 1;
        counter = 32'hABCD;
        @(negedge clk);
        rst_n = 1;
        cycle();
        finish_flag = 0;
        rd_reg(8'd5, 32'h1, "release_rise");
        rd_reg(8'd6, 32'hABCD, "release_capture");
        rd_reg(8'd0, 32'h2, "release_status");
        rd_reg(8'd3, 32'h0, "release_ctrl");
        rd_reg(8'h7F, 32'h0, "unmapped_7f");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lt24_irq_ctrl.md
LT24_IRQ_CTRL -- requirements
Module: lt24_irq_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 2: number of velocity channels (vx/vy pairs), legal 1..8.
REQ-002 The block SHALL have parameter DATA_W, default 32: width of each vx/vy register and of the bus data, legal 16..32.
REQ-003 The block SHALL have parameter PATTERN_W, default 12: pattern register width, legal 1..DATA_W.
REQ-004 The block SHALL have parameter CNT_W, default 32: width of the counter input, legal 1..DATA_W.
REQ-005 The block SHALL have port clock_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port reset_reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port avs_s0_address, input, 8 bits: word address.
REQ-008 The block SHALL have ports avs_s0_read and avs_s0_write, input, 1 bit each: read and write strobes.
REQ-009 The block SHALL have port avs_s0_writedata, input, DATA_W bits: write data.
REQ-010 The block SHALL have port avs_s0_readdata, output, DATA_W bits: registered read data.
REQ-011 The block SHALL have port avs_s0_waitrequest, output, 1 bit: held at constant 0.
REQ-012 The block SHALL have port ins_irq0_irq, output, 1 bit: interrupt request.
REQ-013 The block SHALL have port finish_flag, input, 1 bit: frame-done event, synchronous to clock_clk.
REQ-014 The block SHALL have port counter, input, CNT_W bits: free-running counter value.
REQ-015 The block SHALL have port pattern, output, PATTERN_W bits: pattern register.
REQ-016 The block SHALL have ports vx and vy, output, NUM_CH*DATA_W bits each: channel i occupies bits [i*DATA_W +: DATA_W].

Function
REQ-017 The register map SHALL be: 0 STATUS (RO); 1 COUNTER (RO, live); 2 PATTERN (RW); 3 CTRL (RW); 4 IRQ_CLR (W1C); 5 EVT_CNT (RO); 6 CAPTURE (RO); 8+2i vx[i] (RW); 9+2i vy[i] (RW), for i < NUM_CH.
REQ-018 STATUS SHALL read bit0 = finish_flag (live), bit1 = pending, bit2 = overflow; all other bits 0.
REQ-019 CTRL SHALL hold bit0 = irq_en and bit1 = edge_mode (0 = level, 1 = rising edge); other bits SHALL read 0.
REQ-020 On avs_s0_read, avs_s0_readdata SHALL be valid on the next rising edge (latency 1) and SHALL hold that value until the next read.
REQ-021 Narrow fields SHALL be zero-extended to DATA_W on read.
REQ-022 Reads of unmapped addresses SHALL return 0, and writes to them SHALL be ignored.
REQ-023 Writes to RW registers SHALL take effect on the edge that samples avs_s0_write.
REQ-024 If read and write hit the same address in the same cycle, the read SHALL return the pre-write value.
REQ-025 Writes to PATTERN SHALL store writedata[PATTERN_W-1:0].
REQ-026 A registered copy of finish_flag (prev) SHALL be kept; rising edge = finish_flag & ~prev.
REQ-027 The event SHALL be finish_flag when edge_mode=0, and the rising edge when edge_mode=1.
REQ-028 On an event, pending SHALL be set to 1.
REQ-029 If an event occurs while pending is already 1 and edge_mode=1, overflow SHALL be set to 1.
REQ-030 Writing IRQ_CLR with bit0=1 SHALL clear pending, and with bit2=1 SHALL clear overflow.
REQ-031 If an event and a clear occur in the same cycle, set SHALL win.
REQ-032 ins_irq0_irq SHALL be a registered pending & irq_en, asserted one cycle after pending rises with irq_en=1.
REQ-033 On every rising edge of finish_flag (either mode), CAPTURE SHALL latch counter.
REQ-034 On every rising edge of finish_flag, EVT_CNT (16 bits) SHALL increment, saturating at 0xFFFF.
REQ-035 Any write to EVT_CNT SHALL clear it to 0; if clear and increment coincide, the result SHALL be 1.
REQ-036 Changing edge_mode SHALL NOT alter pending, overflow, CAPTURE or EVT_CNT.

Reset
REQ-037 While reset_reset_n=0, the following SHALL be 0 immediately, independent of clock: pattern, vx, vy, CTRL, pending, overflow, prev, CAPTURE, EVT_CNT, avs_s0_readdata and ins_irq0_irq.
REQ-038 Reset asserted mid-transaction SHALL abort it, with no partial register update.
REQ-039 The first rising edge after reset release SHALL behave as a normal cycle; finish_flag high at release SHALL count as a rising edge (prev=0).

Verification
REQ-040 Write vx[1]=0xDEADBEEF (addr 10) and vy[0]=0x1234 (addr 9), then read both back -> 0xDEADBEEF and 0x00001234 one cycle after each read; vx[31:0]=0, vx[63:32]=0xDEADBEEF.
REQ-041 CTRL=0x3, counter=0x55, pulse finish_flag 0->1 -> CAPTURE=0x55, EVT_CNT=1, STATUS=0x3, irq=1 one cycle after pending.
REQ-042 Edge mode, two rising edges with no clear -> STATUS bit2=1; write IRQ_CLR=0x5 -> STATUS=0x0 (finish_flag low), irq=0.
REQ-043 Level mode, finish_flag held high while IRQ_CLR bit0 is written -> pending stays 1 (set wins); drop finish_flag, clear again -> pending=0.
REQ-044 Drive 65537 rising edges -> EVT_CNT=0xFFFF; write EVT_CNT -> 0.
REQ-045 Assert reset_reset_n=0 mid-clock with all registers non-zero -> all outputs 0 before the next edge; read of unmapped address 0x7F -> 0.
